// File: rtl/midi_note_parser_if.sv
// Byte stream in / note triple out bundle for midi_note_parser.
// The parser connects to the slave modport.
// The UART side or the bench connects to the master modport.
interface midi_note_parser_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic [7:0] Pitch;
  logic [6:0] Velocity;
  logic       Gate;
  logic       NoteEvent;

  modport master (
    output RxData, RxValid,
    input  Pitch, Velocity, Gate, NoteEvent
  );

  modport slave (
    input  RxData, RxValid,
    output Pitch, Velocity, Gate, NoteEvent
  );
endinterface

// File: rtl/midi_note_parser.sv
// MIDI channel-voice byte parser with running status and a channel filter.
// It produces a monophonic, last-note-priority Pitch/Velocity/Gate triple.
// Optional macro MIDI_ALL_NOTES_OFF_EN: a completed CC 123 (all notes off)
// on the accepted channel releases the gate.
module midi_note_parser #(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned OMNI    = 0
) (
  input logic Clk,
  input logic Reset,
  midi_note_parser_if.slave bus
);

  typedef enum logic [2:0] {
    RS_NONE,
    RS_NOTE_OFF,
    RS_NOTE_ON,
    RS_SKIP1,
    RS_SKIP2,
    RS_CC
  } rs_t;

  typedef enum logic {
    EXPECT_D1,
    EXPECT_D2
  } bs_t;

  rs_t        rs;
  bs_t        bs;
  rs_t        status_rs;
  logic [6:0] d1;
  logic [7:0] pitch;
  logic [6:0] velocity;
  logic       gate;
  logic       note_event;
  logic       ch_ok;

  // Running-status type that a channel status byte in RxData would select.
  always_comb begin
    ch_ok     = (OMNI != 0) || (bus.RxData[3:0] == 4'(CHANNEL));
    status_rs = RS_SKIP2;
    if (ch_ok) begin
      case (bus.RxData[6:4])
        3'd0:    status_rs = RS_NOTE_OFF;
        3'd1:    status_rs = RS_NOTE_ON;
`ifdef MIDI_ALL_NOTES_OFF_EN
        3'd3:    status_rs = RS_CC;
`endif
        3'd4,
        3'd5:    status_rs = RS_SKIP1;
        default: status_rs = RS_SKIP2;
      endcase
    end else if (bus.RxData[6:5] == 2'b10) begin
      // A filtered program change or channel pressure still carries only one data byte.
      status_rs = RS_SKIP1;
    end
  end

  // Byte-state and running-status tracking, plus the registered note outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rs         <= RS_NONE;
      bs         <= EXPECT_D1;
      d1         <= '0;
      pitch      <= '0;
      velocity   <= '0;
      gate       <= 1'b0;
      note_event <= 1'b0;
    end else begin
      note_event <= 1'b0;
      if (bus.RxValid) begin
        if (bus.RxData >= 8'hF8) begin
          // A realtime byte may sit inside a message, so no state changes.
        end else if (bus.RxData >= 8'hF0) begin
          rs <= RS_NONE;
          bs <= EXPECT_D1;
        end else if (bus.RxData[7]) begin
          rs <= status_rs;
          bs <= EXPECT_D1;
        end else begin
          case (rs)
            RS_NONE, RS_SKIP1: bs <= EXPECT_D1;
            default: begin
              if (bs == EXPECT_D1) begin
                d1 <= bus.RxData[6:0];
                bs <= EXPECT_D2;
              end else begin
                bs <= EXPECT_D1;
                if (rs == RS_NOTE_ON && bus.RxData[6:0] != 7'd0) begin
                  pitch      <= {1'b0, d1};
                  velocity   <= bus.RxData[6:0];
                  gate       <= 1'b1;
                  note_event <= 1'b1;
                end else if ((rs == RS_NOTE_ON || rs == RS_NOTE_OFF) &&
                             d1 == pitch[6:0] && gate) begin
                  gate       <= 1'b0;
                  note_event <= 1'b1;
                end else if (rs == RS_CC && d1 == 7'd123 && gate) begin
                  gate       <= 1'b0;
                  note_event <= 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.Pitch     = pitch;
  assign bus.Velocity  = velocity;
  assign bus.Gate      = gate;
  assign bus.NoteEvent = note_event;

endmodule
